alto_wb_sram_bridge: RTL
========================

# alto_wb_sram_bridge

Wishbone classic slave that answers the Alto CPU memory interface: it accepts the 16-bit word-addressed master cycles (`wb_adr_o[16:1]`, `wb_sel_o`, `wb_we_o`) and serves them from an external asynchronous 64K×16 SRAM with byte-lane enables. It sits between the CPU's memory master port and the board SRAM pins. It sequences chip-enable, output-enable and write-enable with programmable wait and recovery states, and returns a registered acknowledge.

## Interface
Parameters:
- `WAIT_STATES`, 2, extra ACCESS cycles beyond the first (ACCESS lasts `WAIT_STATES+1` cycles); legal range 0..15.
- `RECOVERY`, 1, cycles with the SRAM deselected after each ACK; legal range 0..7.

Ports:
- `clk_i`  in  1  single clock; all logic on its rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `wb_cyc_i`  in  1  bus cycle valid.
- `wb_stb_i`  in  1  strobe; a request is `wb_cyc_i & wb_stb_i`.
- `wb_we_i`  in  1  1 = write.
- `wb_adr_i`  in  16 (`[16:1]`)  word address.
- `wb_sel_i`  in  2  byte lanes; bit 0 = `[7:0]`, bit 1 = `[15:8]`.
- `wb_dat_i`  in  16  write data.
- `wb_dat_o`  out  16  read data, registered.
- `wb_ack_o`  out  1  one-cycle acknowledge, registered.
- `sram_a_o`  out  16  SRAM address.
- `sram_d_i`  in  16  SRAM data in.
- `sram_d_o`  out  16  SRAM data out.
- `sram_d_oe_o`  out  1  drive enable for the data pins.
- `sram_ce_n_o`, `sram_oe_n_o`, `sram_we_n_o`, `sram_lb_n_o`, `sram_ub_n_o`  out  1 each  active-low SRAM controls.

## Operation
- All outputs are registered. Reset values:
  - `wb_ack_o=0`, `wb_dat_o=0`.
  - `sram_a_o=0`, `sram_d_o=0`, `sram_d_oe_o=0`.
  - all `_n` controls = 1.
- States: IDLE, SETUP, ACCESS, ACK, RECOVER.
- IDLE:
  - On request with `wb_sel_i != 0`: latch address, data, `we` and `sel` into the SRAM output registers, then go to SETUP.
  - On request with `wb_sel_i == 0`: go directly to ACK with no SRAM strobes.
  - `wb_stb_i` without `wb_cyc_i` is ignored.
- SETUP (1 cycle):
  - `ce_n=0`.
  - Read: `oe_n=0`, `lb_n=ub_n=0`.
  - Write: `d_oe=1`, `lb_n=~sel[0]`, `ub_n=~sel[1]`, `we_n=1`.
  - Next state: ACCESS, wait counter loaded with `WAIT_STATES`.
- ACCESS (`WAIT_STATES+1` cycles):
  - Write: `we_n=0`.
  - The counter decrements each cycle and the state exits when it reaches 0.
  - Read: `wb_dat_o` captures the full word from `sram_d_i` on the exiting edge, whatever `sel` is.
- ACK (1 cycle):
  - `wb_ack_o=1`, `ce_n/oe_n/we_n/lb_n/ub_n=1`.
  - `d_oe` stays 1 through ACK for writes, giving hold time, then drops.
  - Next state: RECOVER if `RECOVERY>0`, else IDLE.
- RECOVER: SRAM deselected and `d_oe=0` for `RECOVERY` cycles, then IDLE.
- `wb_dat_o` holds its last captured value until the next read capture; writes leave it unchanged.
- Abort: if `wb_cyc_i` drops in SETUP or ACCESS, go to RECOVER on the next edge with all strobes deasserted and no ACK. Contents of an aborted write word are undefined.
- Reset in any state: IDLE with reset output values on that edge; a pending cycle is never acknowledged.

## Timing
- Let cycle 0 be the IDLE cycle in which the request is first sampled.
- SETUP is cycle 1, ACCESS is cycles 2..`WAIT_STATES+2`, and `wb_ack_o` is high in cycle `WAIT_STATES+3`. With defaults, ACK is in cycle 5.
- A `sel=0` request gets ACK in cycle 1.
- Next request sampling:
  - First sampled cycle is `WAIT_STATES+4+RECOVERY`, which is 7 by default.
  - With `RECOVERY=0`, a request held in the cycle after ACK is sampled as a new request.
- `wb_ack_o` is never high for more than one consecutive cycle.
- `sram_we_n_o` is never low while `sram_ce_n_o` is high.
- `sram_a_o` is stable from SETUP through ACK.
- `sram_d_oe_o` and `sram_oe_n_o=0` never coincide.

## Test plan
- Read, defaults, SRAM model returns `16'hA5C3` at address `16'h1234`: `wb_ack_o` high in cycle 5 only, `wb_dat_o=16'hA5C3`, `oe_n` low in cycles 1–4, `we_n` stays 1.
- Write `16'hBEEF` with `sel=2'b01` to `16'h0042` over SRAM holding `16'h1111`: `we_n` low in cycles 2–4, `lb_n=0`, `ub_n=1`; a readback returns `16'h11EF`.
- `WAIT_STATES=0`, `RECOVERY=0`, back-to-back reads at addresses 0 and 1 with `stb` held: ACKs in cycles 3 and 7, correct data on each.
- `sel=2'b00` write: ACK in cycle 1, `ce_n` never low, SRAM contents unchanged.
- `wb_cyc_i` dropped in cycle 3 of a write: no ACK, all strobes high from cycle 4, IDLE reached after `RECOVERY` cycles.
- `rst_i` asserted in cycle 2 of a read: every output at its reset value after that edge, and no ACK follows.

Source files
------------

// File: rtl/alto_wb_sram_bridge.sv
// Wishbone classic slave serving Alto CPU word cycles from an asynchronous 64Kx16 SRAM,
// with programmable wait/recovery states and fully registered bus and SRAM outputs.
module alto_wb_sram_bridge #(
  parameter int unsigned WAIT_STATES = 2,
  parameter int unsigned RECOVERY    = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [16:1] wb_adr_i,
  input  logic [1:0]  wb_sel_i,
  input  logic [15:0] wb_dat_i,
  output logic [15:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic [15:0] sram_a_o,
  input  logic [15:0] sram_d_i,
  output logic [15:0] sram_d_o,
  output logic        sram_d_oe_o,
  output logic        sram_ce_n_o,
  output logic        sram_oe_n_o,
  output logic        sram_we_n_o,
  output logic        sram_lb_n_o,
  output logic        sram_ub_n_o
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SETUP   = 3'd1;
  localparam logic [2:0] ST_ACCESS  = 3'd2;
  localparam logic [2:0] ST_ACK     = 3'd3;
  localparam logic [2:0] ST_RECOVER = 3'd4;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);
  localparam logic [3:0] REC_LOAD  = 4'((RECOVERY > 32'd0) ? (RECOVERY - 32'd1) : 32'd0);
  // After ACK or an abort the bridge rests in RECOVER only when recovery cycles exist.
  localparam logic [2:0] ST_POST   = (RECOVERY > 32'd0) ? ST_RECOVER : ST_IDLE;

  logic [2:0]  state_r, state_s;
  logic [3:0]  cnt_r, cnt_s;
  logic        we_r, we_s;
  logic [1:0]  sel_r, sel_s;
  logic [15:0] a_s, d_s, dat_s;
  logic        req_s, ack_s, d_oe_s;
  logic        ce_n_s, oe_n_s, we_n_s, lb_n_s, ub_n_s;

  assign req_s = wb_cyc_i & wb_stb_i;

  // Next state, wait/recovery counter and latched request fields.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    we_s    = we_r;
    sel_s   = sel_r;
    a_s     = sram_a_o;
    d_s     = sram_d_o;
    dat_s   = wb_dat_o;
    case (state_r)
      ST_IDLE: begin
        if (req_s) begin
          we_s  = wb_we_i;
          sel_s = wb_sel_i;
          if (wb_sel_i != 2'b00) begin
            a_s     = wb_adr_i;
            d_s     = wb_dat_i;
            state_s = ST_SETUP;
          end else begin
            state_s = ST_ACK;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (!wb_cyc_i) begin
          state_s = ST_POST;
          cnt_s   = REC_LOAD;
        end else begin
          state_s = ST_ACCESS;
          cnt_s   = WAIT_LOAD;
        end
      end
      ST_ACCESS: begin
        if (!wb_cyc_i) begin
          state_s = ST_POST;
          cnt_s   = REC_LOAD;
        end else if (cnt_r == 4'd0) begin
          state_s = ST_ACK;
          if (!we_r) begin
            dat_s = sram_d_i;
          end else begin
            dat_s = wb_dat_o;
          end
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      ST_ACK: begin
        state_s = ST_POST;
        cnt_s   = REC_LOAD;
      end
      ST_RECOVER: begin
        if (cnt_r == 4'd0) begin
          state_s = ST_IDLE;
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // SRAM strobes and acknowledge decoded from the state being entered, so they register with it.
  always_comb begin
    ack_s  = (state_s == ST_ACK);
    ce_n_s = 1'b1;
    oe_n_s = 1'b1;
    we_n_s = 1'b1;
    lb_n_s = 1'b1;
    ub_n_s = 1'b1;
    d_oe_s = 1'b0;
    if ((state_s == ST_SETUP) || (state_s == ST_ACCESS)) begin
      ce_n_s = 1'b0;
      if (we_s) begin
        d_oe_s = 1'b1;
        lb_n_s = ~sel_s[0];
        ub_n_s = ~sel_s[1];
        we_n_s = (state_s != ST_ACCESS);
      end else begin
        oe_n_s = 1'b0;
        lb_n_s = 1'b0;
        ub_n_s = 1'b0;
      end
    end else if (state_s == ST_ACK) begin
      // Data keeps driving through ACK for write hold time; a sel=0 cycle never drove it.
      d_oe_s = we_s & (sel_s != 2'b00);
    end else begin
      d_oe_s = 1'b0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 4'd0;
      we_r        <= 1'b0;
      sel_r       <= 2'b00;
      wb_ack_o    <= 1'b0;
      wb_dat_o    <= 16'h0000;
      sram_a_o    <= 16'h0000;
      sram_d_o    <= 16'h0000;
      sram_d_oe_o <= 1'b0;
      sram_ce_n_o <= 1'b1;
      sram_oe_n_o <= 1'b1;
      sram_we_n_o <= 1'b1;
      sram_lb_n_o <= 1'b1;
      sram_ub_n_o <= 1'b1;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      we_r        <= we_s;
      sel_r       <= sel_s;
      wb_ack_o    <= ack_s;
      wb_dat_o    <= dat_s;
      sram_a_o    <= a_s;
      sram_d_o    <= d_s;
      sram_d_oe_o <= d_oe_s;
      sram_ce_n_o <= ce_n_s;
      sram_oe_n_o <= oe_n_s;
      sram_we_n_o <= we_n_s;
      sram_lb_n_o <= lb_n_s;
      sram_ub_n_o <= ub_n_s;
    end
  end

endmodule
